// File: rtl/rotation_bbox_calc.sv
// rtl/rotation_bbox_calc.sv - bounding box and output size of the rotated 64x64 image
// Walks the upstream corner mux through all eight coordinates and reduces them to min/max per axis.
module rotation_bbox_calc #(
    parameter int WARMUP  = 12,
    parameter int SEL_LAT = 2,
    parameter int DIM_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [2:0]              selection,
    input  logic signed [32:0]      selected_value,
    output logic                    busy,
    output logic                    done,
    output logic signed [32:0]      xmin,
    output logic signed [32:0]      xmax,
    output logic signed [32:0]      ymin,
    output logic signed [32:0]      ymax,
    output logic [DIM_W-1:0]        out_width,
    output logic [DIM_W-1:0]        out_height
);

    localparam int WCW = $clog2(WARMUP + 1);
    localparam int SCW = $clog2(SEL_LAT + 1);
    localparam logic [14:0] DIM_MAX = 15'((2 ** DIM_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WARM, S_WAIT, S_CAPT, S_CALC, S_DONE
    } state_t;

    state_t                 r_state, w_next;
    logic [WCW-1:0]         r_warm_cnt;
    logic [SCW-1:0]         r_wait_cnt;
    logic [2:0]             r_sel;
    logic                   r_busy, r_done;
    logic signed [32:0]     r_xmin, r_xmax, r_ymin, r_ymax;
    logic [DIM_W-1:0]       r_width, r_height;
    logic [DIM_W-1:0]       w_dim_x, w_dim_y;
    logic                   w_warm_last, w_wait_last;

    // ceil(max - min) + 1 in whole pixels, saturated to the output width
    function automatic logic [DIM_W-1:0] dim_of(input logic signed [32:0] mx,
                                                input logic signed [32:0] mn);
        logic signed [33:0] span;
        logic [14:0]        full;
        span = {mx[32], mx} - {mn[32], mn};
        full = {1'b0, span[33:20]} + {14'd0, |span[19:0]} + 15'd1;
        if (full > DIM_MAX) dim_of = '1;
        else                dim_of = full[DIM_W-1:0];
    endfunction

    assign w_warm_last = (r_warm_cnt == WCW'(WARMUP - 1));
    assign w_wait_last = (r_wait_cnt == SCW'(SEL_LAT - 1));
    assign w_dim_x     = dim_of(r_xmax, r_xmin);
    assign w_dim_y     = dim_of(r_ymax, r_ymin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_WARM;
            S_WARM:  if (w_warm_last) w_next = S_WAIT;
            S_WAIT:  if (w_wait_last) w_next = S_CAPT;
            S_CAPT:  w_next = (r_sel == 3'd7) ? S_CALC : S_WAIT;
            S_CALC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_warm_cnt <= '0;
            r_wait_cnt <= '0;
            r_sel      <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_ymin     <= '0;
            r_ymax     <= '0;
            r_width    <= '0;
            r_height   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_warm_cnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_WARM: begin
                    if (w_warm_last) begin
                        r_sel      <= 3'd0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 1'b1;
                    end
                end
                S_WAIT: r_wait_cnt <= r_wait_cnt + 1'b1;
                S_CAPT: begin
                    // index 0/4 seeds the axis; later samples replace only on strict improvement
                    if (!r_sel[2]) begin
                        if (r_sel[1:0] == 2'd0 || selected_value < r_xmin) r_xmin <= selected_value;
                        if (r_sel[1:0] == 2'd0 || selected_value > r_xmax) r_xmax <= selected_value;
                    end else begin
                        if (r_sel[1:0] == 2'd0 || selected_value < r_ymin) r_ymin <= selected_value;
                        if (r_sel[1:0] == 2'd0 || selected_value > r_ymax) r_ymax <= selected_value;
                    end
                    r_wait_cnt <= '0;
                    if (r_sel != 3'd7) r_sel <= r_sel + 3'd1;
                end
                S_CALC: begin
                    r_width  <= w_dim_x;
                    r_height <= w_dim_y;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_sel  <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    assign selection  = r_sel;
    assign busy       = r_busy;
    assign done       = r_done;
    assign xmin       = r_xmin;
    assign xmax       = r_xmax;
    assign ymin       = r_ymin;
    assign ymax       = r_ymax;
    assign out_width  = r_width;
    assign out_height = r_height;

endmodule
